tilelink_ram_slave: RTL and testbench
=====================================

// Module: tilelink_ram_slave
// PURPOSE
//  TL-UL responder (slave end of tilelink_if, modport s) fronting a single-port word RAM.
//  - Accepts Get / PutFullData / PutPartialData on channel A.
//  - Returns AccessAckData / AccessAck on channel D.
//  - One response buffered at a time; back-to-back throughput of 1 req/cycle while D drains.
//  - Sits behind the crossbar as the on-chip scratchpad / boot RAM target.
// PARAMETERS
//  MASTERS    2           number of sources; source width = $clog2(MASTERS)
//  SLAVES     2           number of sinks; sink width = $clog2(SLAVES)
//  ADDR_WIDTH 32          address bits
//  DATA_WIDTH 32          data bus width in BYTES (bus = DATA_WIDTH*8 bits)
//  DEPTH      1024        RAM words of DATA_WIDTH bytes; power of two
//  BASE_ADDR  0           byte base address of this slave; aligned to DEPTH*DATA_WIDTH
//  SINK_ID    0           value driven on d_sink
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 synchronous active-high reset
//  a_code     in   3                 A opcode: 0 PutFull, 1 PutPartial, 4 Get
//  a_param    in   3                 ignored
//  a_size     in   $clog2(DATA_WIDTH) log2 bytes
//  a_source   in   $clog2(MASTERS)   requester id
//  a_address  in   ADDR_WIDTH        byte address
//  a_mask     in   DATA_WIDTH        byte lanes
//  a_data     in   DATA_WIDTH*8      write data
//  a_corrupt  in   1                 write data corrupt
//  a_valid    in   1                 A valid
//  a_ready    out  1                 A ready
//  d_opcode   out  3                 0 AccessAck, 1 AccessAckData
//  d_param    out  2                 always 0
//  d_size     out  $clog2(DATA_WIDTH) echo of a_size
//  d_source   out  $clog2(MASTERS)   echo of a_source
//  d_sink     out  $clog2(SLAVES)    SINK_ID
//  d_denied   out  1                 request refused
//  d_data     out  DATA_WIDTH*8      read data; 0 for AccessAck
//  d_corrupt  out  1                 read data corrupt
//  d_valid    out  1                 D valid
//  d_ready    in   1                 D ready
// BEHAVIOUR
//  - Reset: d_valid=0; d_opcode/d_size/d_source/d_denied/d_data/d_corrupt=0; d_param=0.
//    RAM contents are not reset. a_ready is combinational and equals 1 out of reset.
//  - a_ready = !d_valid || d_ready. A handshake = a_valid && a_ready.
//  - Index: word = a_address[$clog2(DATA_WIDTH) +: $clog2(DEPTH)].
//  - On A handshake at cycle N:
//    - Put*: RAM bytes with a_mask[i]=1 are written at N. PutFull uses a_mask as given.
//    - Get: RAM read at N.
//  - Response: D registered, d_valid=1 from N+1. Fields are held stable until D handshake.
//    - d_opcode = Get ? 1 : 0; d_size/d_source latched; d_sink=SINK_ID.
//    - Get: d_data = full word at the index. Put: d_data = 0.
//    - d_corrupt = 0 for Get; for Put, d_corrupt = 0 and a_corrupt is ignored.
//  - Simultaneous D handshake and new A handshake in the same cycle: the new response
//    replaces the old at the next edge, with no bubble.
//  - Get immediately after Put to the same word returns the written data (write at N,
//    read at N+1 or later).
//  - D handshake with no new A: d_valid=0 at next edge.
//  - rst asserted mid-transaction: the pending response is dropped, d_valid=0 next cycle;
//    partial writes already committed remain.
//  - Address wraps modulo DEPTH*DATA_WIDTH when error checking is compiled out.
// CONFIGURATION
//  TL_SLAVE_ERR_EN defined:
//    - Requests are refused when any of these holds: address outside
//      [BASE_ADDR, BASE_ADDR+DEPTH*DATA_WIDTH); opcode not in {0,1,4}; a_size > $clog2(DATA_WIDTH).
//    - Refused requests make no RAM access and respond with d_denied=1. Opcode is
//      AccessAckData for Get and AccessAck otherwise; d_data=0. d_corrupt=1 on a denied Get.
//  TL_SLAVE_ERR_EN undefined:
//    - d_denied is tied 0; the upper address bits are ignored (aliasing).
//    - Unknown opcodes are treated as Get.
// TESTING
//  1 Reset, then PutFull addr 0x10, data 0xDEADBEEF, mask 0xF, src 1 -> next cycle d_valid=1,
//    d_opcode=0, d_source=1, d_data=0.
//  2 Get 0x10 issued in the same cycle as the D handshake of test 1 -> d_opcode=1,
//    d_data=0xDEADBEEF, no bubble.
//  3 PutPartial 0x10, mask 0x2, data 0x0000AA00, then Get 0x10 -> d_data=0xDEADAAEF.
//  4 d_ready=0 for 5 cycles with a Get pending -> a_ready=0, D fields stable;
//    d_ready=1 -> accepted next A.
//  5 rst pulse while d_valid=1 -> d_valid=0 next cycle; a_ready=1.
//  6 TL_SLAVE_ERR_EN, Get at BASE_ADDR+DEPTH*4 -> d_denied=1, d_corrupt=1, RAM unchanged;
//    without the macro the same Get aliases to word 0.

Source files
------------

// File: rtl/tilelink_ram_slave_if.sv
// TL-UL channel A/D bundle between one requester (modport m) and one responder (modport s).
// Latency: none, wires only.
// Backpressure: valid/ready on both channels.
interface tilelink_if #(
  parameter int MASTERS    = 2,
  parameter int SLAVES     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SZ_W  = $clog2(DATA_WIDTH);
  localparam int SRC_W = $clog2(MASTERS);
  localparam int SNK_W = $clog2(SLAVES);
  localparam int BUS_W = DATA_WIDTH * 8;

  // Channel A: requests
  logic [2:0]            a_code;
  logic [2:0]            a_param;
  logic [SZ_W-1:0]       a_size;
  logic [SRC_W-1:0]      a_source;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [DATA_WIDTH-1:0] a_mask;
  logic [BUS_W-1:0]      a_data;
  logic                  a_corrupt;
  logic                  a_valid;
  logic                  a_ready;

  // Channel D: responses
  logic [2:0]            d_opcode;
  logic [1:0]            d_param;
  logic [SZ_W-1:0]       d_size;
  logic [SRC_W-1:0]      d_source;
  logic [SNK_W-1:0]      d_sink;
  logic                  d_denied;
  logic [BUS_W-1:0]      d_data;
  logic                  d_corrupt;
  logic                  d_valid;
  logic                  d_ready;

  modport m (
    output a_code, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    input  a_ready,
    input  d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    output d_ready
  );

  modport s (
    input  a_code, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid,
    output a_ready,
    output d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt, d_valid,
    input  d_ready
  );
endinterface

// File: rtl/tilelink_ram_slave.sv
// TL-UL responder fronting a single-port byte-writable word RAM (scratchpad / boot RAM).
// Latency: response on D one cycle after the A handshake; 1 req/cycle while D drains.
// Backpressure: single response register; a_ready = !d_valid || d_ready. Optional macro TL_SLAVE_ERR_EN.
module tilelink_ram_slave #(
  parameter int                    MASTERS    = 2,
  parameter int                    SLAVES     = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    SINK_ID    = 0
) (
  input logic   clk,
  input logic   rst,
  tilelink_if.s tl
);
  localparam int OFF_W = $clog2(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SZ_W  = $clog2(DATA_WIDTH);
  localparam int SRC_W = $clog2(MASTERS);
  localparam int SNK_W = $clog2(SLAVES);
  localparam int BUS_W = DATA_WIDTH * 8;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  logic [BUS_W-1:0] mem_q [DEPTH];

  logic             a_hs;
  logic             is_get;
  logic             denied;
  logic [IDX_W-1:0] idx;
  logic [BUS_W-1:0] rd_word;

  logic             d_vld_q,     d_vld_d;
  logic [2:0]       d_opcode_q,  d_opcode_d;
  logic [SZ_W-1:0]  d_size_q,    d_size_d;
  logic [SRC_W-1:0] d_source_q,  d_source_d;
  logic             d_denied_q,  d_denied_d;
  logic [BUS_W-1:0] d_data_q,    d_data_d;
  logic             d_corrupt_q, d_corrupt_d;

  assign tl.a_ready = !d_vld_q || tl.d_ready;
  assign a_hs       = tl.a_valid && tl.a_ready;
  assign idx        = tl.a_address[OFF_W +: IDX_W];
  assign rd_word    = mem_q[idx];

`ifdef TL_SLAVE_ERR_EN
  // Window size as a wider-than-address value so the top of a full-range window still compares.
  localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(DEPTH * DATA_WIDTH);
  localparam logic [SZ_W-1:0]     MAX_SIZE = SZ_W'(SZ_W);

  logic [ADDR_WIDTH:0] offset;
  logic                in_range;
  logic                op_ok;
  logic                size_ok;

  // BASE_ADDR is window-aligned, so an unsigned offset below SPAN means inside the window;
  // addresses below the base wrap to a huge offset and are refused.
  assign offset   = {1'b0, tl.a_address - BASE_ADDR};
  assign in_range = offset < SPAN;
  assign op_ok    = (tl.a_code == OP_PUT_FULL) || (tl.a_code == OP_PUT_PART) || (tl.a_code == OP_GET);
  assign size_ok  = tl.a_size <= MAX_SIZE;
  assign denied   = !(in_range && op_ok && size_ok);
  assign is_get   = tl.a_code == OP_GET;
`else
  // No checking: upper address bits alias, anything that is not a Put reads.
  assign denied   = 1'b0;
  assign is_get   = !((tl.a_code == OP_PUT_FULL) || (tl.a_code == OP_PUT_PART));
`endif

  // a_param and a_corrupt carry nothing this responder acts on.
  logic unused_ok;
  assign unused_ok = ^{tl.a_param, tl.a_corrupt, tl.a_address};

  // Byte-lane RAM write for accepted, non-refused Puts; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && a_hs && !is_get && !denied) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (tl.a_mask[i]) mem_q[idx][i*8 +: 8] <= tl.a_data[i*8 +: 8];
      end
    end
  end

  // Next response: a new request overwrites the slot (no bubble), a lone D handshake empties it.
  always_comb begin
    d_vld_d     = d_vld_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_data_d    = d_data_q;
    d_corrupt_d = d_corrupt_q;
    if (a_hs) begin
      d_vld_d     = 1'b1;
      d_opcode_d  = is_get ? OP_ACK_DATA : OP_ACK;
      d_size_d    = tl.a_size;
      d_source_d  = tl.a_source;
      d_denied_d  = denied;
      d_data_d    = (is_get && !denied) ? rd_word : '0;
      d_corrupt_d = is_get && denied;
    end else if (tl.d_ready) begin
      d_vld_d     = 1'b0;
    end
  end

  // Response register; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_vld_q     <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
      d_corrupt_q <= 1'b0;
    end else begin
      d_vld_q     <= d_vld_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_data_q    <= d_data_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  assign tl.d_valid   = d_vld_q;
  assign tl.d_opcode  = d_opcode_q;
  assign tl.d_param   = 2'b00;
  assign tl.d_size    = d_size_q;
  assign tl.d_source  = d_source_q;
  assign tl.d_sink    = SNK_W'(SINK_ID);
  assign tl.d_denied  = d_denied_q;
  assign tl.d_data    = d_data_q;
  assign tl.d_corrupt = d_corrupt_q;
endmodule

// File: tb/tb_tilelink_ram_slave.sv
// Bench for tilelink_ram_slave: directed scenarios plus randomized traffic against a queue/array model.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Works with and without TL_SLAVE_ERR_EN defined.
module tb_tilelink_ram_slave;
  localparam int MASTERS = 2;
  localparam int SLAVES  = 2;
  localparam int AW      = 32;
  localparam int DW      = 4;
  localparam int DEPTH   = 64;
  localparam int SINK_ID = 1;
  localparam int SPAN    = DEPTH * DW;

  typedef struct packed {
    logic        vld;
    logic [2:0]  op;
    logic [1:0]  size;
    logic        src;
    logic        den;
    logic        cor;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] mem_m [DEPTH];
  rsp_t        pend[$];

  always #5 clk = ~clk;

  tilelink_if #(.MASTERS(MASTERS), .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) tl ();

  tilelink_ram_slave #(
    .MASTERS(MASTERS), .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DEPTH(DEPTH), .BASE_ADDR(32'h0), .SINK_ID(SINK_ID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tl(tl)
  );

  function automatic rsp_t mk(input logic v, input logic [2:0] op, input logic [1:0] sz,
                              input logic src, input logic den, input logic cor, input logic [31:0] d);
    rsp_t r;
    r.vld = v; r.op = op; r.size = sz; r.src = src; r.den = den; r.cor = cor; r.data = d;
    return r;
  endfunction

  function automatic rsp_t dbus();
    return mk(tl.d_valid, tl.d_opcode, tl.d_size, tl.d_source, tl.d_denied, tl.d_corrupt, tl.d_data);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [2:0] code, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic src, input logic [1:0] size);
    tl.a_valid = 1'b1; tl.a_code = code; tl.a_address = addr; tl.a_mask = mask;
    tl.a_data = data; tl.a_source = src; tl.a_size = size; tl.a_param = 3'd0; tl.a_corrupt = 1'b0;
  endtask

  // Issue one request with D held off, so the response stays visible afterwards.
  task automatic req(input logic [2:0] code, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic src, input logic [1:0] size);
    set_a(code, addr, mask, data, src, size);
    tl.d_ready = 1'b0;
    step();
    tl.a_valid = 1'b0;
  endtask

  task automatic drain();
    tl.d_ready = 1'b1;
    step();
    tl.d_ready = 1'b0;
  endtask

  // Reference behaviour: word index by plain division, refusal rules, byte-lane writes.
  task automatic model_req(input logic [2:0] code, input logic [31:0] addr, input logic [1:0] size,
                           input logic src, input logic [3:0] mask, input logic [31:0] data,
                           output rsp_t r);
    int w;
    bit get, den;
    w = int'((addr / DW) % DEPTH);
`ifdef TL_SLAVE_ERR_EN
    get = (code == 3'd4);
    den = (addr >= SPAN) || !(code == 3'd0 || code == 3'd1 || code == 3'd4) || (size > 2'd2);
`else
    get = !(code == 3'd0 || code == 3'd1);
    den = 1'b0;
`endif
    if (!get && !den) begin
      for (int i = 0; i < DW; i++) if (mask[i]) mem_m[w][8*i +: 8] = data[8*i +: 8];
    end
    r = mk(1'b1, get ? 3'd1 : 3'd0, size, src, den, get && den, (get && !den) ? mem_m[w] : 32'h0);
  endtask

  task automatic test_reset();
    rsp_t got;
    rst = 1'b1;
    repeat (3) step();
    got = dbus();
    vectors++; if (got !== mk(0, 0, 0, 0, 0, 0, 0)) begin miscompares++; $display("FAIL reset_d got %h want %h", got, mk(0, 0, 0, 0, 0, 0, 0)); end
    vectors++; if (tl.d_param !== 2'b00) begin miscompares++; $display("FAIL reset_param got %0d want 0", tl.d_param); end
    vectors++; if (tl.d_sink !== 1'(SINK_ID)) begin miscompares++; $display("FAIL reset_sink got %0d want %0d", tl.d_sink, SINK_ID); end
    vectors++; if (tl.a_ready !== 1'b1) begin miscompares++; $display("FAIL reset_a_ready got %b want 1", tl.a_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_put_full();
    rsp_t got;
    req(3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 0, 2, 1, 0, 0, 0)) begin miscompares++; $display("FAIL put_full got %h want %h", got, mk(1, 0, 2, 1, 0, 0, 0)); end
  endtask

  task automatic test_get_no_bubble();
    rsp_t got;
    set_a(3'd4, 32'h10, 4'h0, 32'h0, 1'b0, 2'd2);
    tl.d_ready = 1'b1;
    #1;
    vectors++; if (tl.a_ready !== 1'b1) begin miscompares++; $display("FAIL overlap_a_ready got %b want 1", tl.a_ready); end
    step();
    tl.a_valid = 1'b0; tl.d_ready = 1'b0;
    got = dbus();
    vectors++; if (got !== mk(1, 1, 2, 0, 0, 0, 32'hDEADBEEF)) begin miscompares++; $display("FAIL get_no_bubble got %h want %h", got, mk(1, 1, 2, 0, 0, 0, 32'hDEADBEEF)); end
    drain();
    vectors++; if (tl.d_valid !== 1'b0) begin miscompares++; $display("FAIL drain_d_valid got %b want 0", tl.d_valid); end
  endtask

  task automatic test_put_partial();
    rsp_t got;
    req(3'd1, 32'h10, 4'h2, 32'h0000AA00, 1'b1, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 0, 2, 1, 0, 0, 0)) begin miscompares++; $display("FAIL put_partial_ack got %h want %h", got, mk(1, 0, 2, 1, 0, 0, 0)); end
    drain();
    req(3'd4, 32'h10, 4'h0, 32'h0, 1'b0, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 1, 2, 0, 0, 0, 32'hDEADAAEF)) begin miscompares++; $display("FAIL put_partial_read got %h want %h", got, mk(1, 1, 2, 0, 0, 0, 32'hDEADAAEF)); end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_t got, held;
    held = mk(1, 1, 2, 1, 0, 0, 32'hDEADAAEF);
    req(3'd4, 32'h10, 4'h0, 32'h0, 1'b1, 2'd2);
    set_a(3'd0, 32'h20, 4'hF, 32'h01234567, 1'b0, 2'd2);
    for (int c = 0; c < 5; c++) begin
      #1;
      got = dbus();
      vectors++; if (tl.a_ready !== 1'b0) begin miscompares++; $display("FAIL stall_a_ready cyc %0d got %b want 0", c, tl.a_ready); end
      vectors++; if (got !== held) begin miscompares++; $display("FAIL stall_hold cyc %0d got %h want %h", c, got, held); end
      step();
    end
    tl.d_ready = 1'b1;
    #1;
    vectors++; if (tl.a_ready !== 1'b1) begin miscompares++; $display("FAIL release_a_ready got %b want 1", tl.a_ready); end
    step();
    tl.a_valid = 1'b0; tl.d_ready = 1'b0;
    got = dbus();
    vectors++; if (got !== mk(1, 0, 2, 0, 0, 0, 0)) begin miscompares++; $display("FAIL release_put got %h want %h", got, mk(1, 0, 2, 0, 0, 0, 0)); end
    drain();
    req(3'd4, 32'h20, 4'h0, 32'h0, 1'b1, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 1, 2, 1, 0, 0, 32'h01234567)) begin miscompares++; $display("FAIL release_readback got %h want %h", got, mk(1, 1, 2, 1, 0, 0, 32'h01234567)); end
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_t got;
    req(3'd4, 32'h20, 4'h0, 32'h0, 1'b1, 2'd2);
    vectors++; if (tl.d_valid !== 1'b1) begin miscompares++; $display("FAIL pre_rst_d_valid got %b want 1", tl.d_valid); end
    rst = 1'b1;
    step();
    got = dbus();
    vectors++; if (got !== mk(0, 0, 0, 0, 0, 0, 0)) begin miscompares++; $display("FAIL mid_rst_drop got %h want %h", got, mk(0, 0, 0, 0, 0, 0, 0)); end
    vectors++; if (tl.a_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_a_ready got %b want 1", tl.a_ready); end
    rst = 1'b0;
    step();
    req(3'd4, 32'h10, 4'h0, 32'h0, 1'b0, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 1, 2, 0, 0, 0, 32'hDEADAAEF)) begin miscompares++; $display("FAIL post_rst_ram got %h want %h", got, mk(1, 1, 2, 0, 0, 0, 32'hDEADAAEF)); end
    drain();
  endtask

  task automatic test_out_of_range();
    rsp_t got, want;
    logic [31:0] word0;
    req(3'd0, 32'h0, 4'hF, 32'h12345678, 1'b0, 2'd2);
    drain();
    req(3'd4, SPAN, 4'h0, 32'h0, 1'b1, 2'd2);
    got = dbus();
`ifdef TL_SLAVE_ERR_EN
    want = mk(1, 1, 2, 1, 1, 1, 0);
`else
    want = mk(1, 1, 2, 1, 0, 0, 32'h12345678);
`endif
    vectors++; if (got !== want) begin miscompares++; $display("FAIL oob_get got %h want %h", got, want); end
    drain();
    req(3'd0, SPAN, 4'hF, 32'hCAFEF00D, 1'b0, 2'd2);
    got = dbus();
`ifdef TL_SLAVE_ERR_EN
    want = mk(1, 0, 2, 0, 1, 0, 0);
    word0 = 32'h12345678;
`else
    want = mk(1, 0, 2, 0, 0, 0, 0);
    word0 = 32'hCAFEF00D;
`endif
    vectors++; if (got !== want) begin miscompares++; $display("FAIL oob_put got %h want %h", got, want); end
    drain();
    req(3'd4, 32'h0, 4'h0, 32'h0, 1'b0, 2'd2);
    got = dbus();
    vectors++; if (got !== mk(1, 1, 2, 0, 0, 0, word0)) begin miscompares++; $display("FAIL oob_word0 got %h want %h", got, mk(1, 1, 2, 0, 0, 0, word0)); end
    drain();
    req(3'd2, 32'h0, 4'hF, 32'h55555555, 1'b1, 2'd2);
    got = dbus();
`ifdef TL_SLAVE_ERR_EN
    want = mk(1, 0, 2, 1, 1, 0, 0);
`else
    want = mk(1, 1, 2, 1, 0, 0, word0);
`endif
    vectors++; if (got !== want) begin miscompares++; $display("FAIL bad_opcode got %h want %h", got, want); end
    drain();
    req(3'd4, 32'h0, 4'h0, 32'h0, 1'b0, 2'd3);
    got = dbus();
`ifdef TL_SLAVE_ERR_EN
    want = mk(1, 1, 3, 0, 1, 1, 0);
`else
    want = mk(1, 1, 3, 0, 0, 0, word0);
`endif
    vectors++; if (got !== want) begin miscompares++; $display("FAIL big_size got %h want %h", got, want); end
    drain();
  endtask

  task automatic test_random();
    rsp_t got, r;
    logic [31:0] d;
    bit model_a_rdy;
    // Fill every word back to back so the model knows the whole RAM.
    tl.d_ready = 1'b1;
    for (int w = 0; w < DEPTH; w++) begin
      d = $urandom;
      set_a(3'd0, 32'(w * DW), 4'hF, d, 1'b0, 2'd2);
      mem_m[w] = d;
      step();
    end
    tl.a_valid = 1'b0;
    step();
    tl.d_ready = 1'b0;
    pend.delete();
    for (int c = 0; c < 3000; c++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      tl.a_valid = ($urandom_range(0, 99) < 60);
      tl.a_code = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 9) ? 3'd1 : 3'($urandom_range(0, 7));
      tl.a_address = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, SPAN - 1));
      tl.a_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      tl.a_mask = 4'($urandom_range(0, 15));
      tl.a_data = $urandom;
      tl.a_source = 1'($urandom_range(0, 1));
      tl.a_param = 3'($urandom_range(0, 7));
      tl.a_corrupt = 1'($urandom_range(0, 1));
      tl.d_ready = ($urandom_range(0, 99) < 70);
      #1;
      got = dbus();
      vectors++; if (tl.d_valid !== (pend.size() != 0)) begin miscompares++; $display("FAIL rand_d_valid cyc %0d got %b want %b", c, tl.d_valid, pend.size() != 0); end
      if (pend.size() != 0) begin
        vectors++; if (got !== pend[0]) begin miscompares++; $display("FAIL rand_rsp cyc %0d got %h want %h", c, got, pend[0]); end
      end
      model_a_rdy = (pend.size() == 0) || tl.d_ready;
      vectors++; if (tl.a_ready !== model_a_rdy) begin miscompares++; $display("FAIL rand_a_ready cyc %0d got %b want %b", c, tl.a_ready, model_a_rdy); end
      if (pend.size() != 0 && tl.d_ready) void'(pend.pop_front());
      if (tl.a_valid && model_a_rdy) begin
        model_req(tl.a_code, tl.a_address, tl.a_size, tl.a_source, tl.a_mask, tl.a_data, r);
        pend.push_back(r);
      end
      step();
    end
    tl.a_valid = 1'b0;
    tl.d_ready = 1'b1;
    step();
    vectors++; if (tl.d_valid !== 1'b0) begin miscompares++; $display("FAIL rand_final_drain got %b want 0", tl.d_valid); end
  endtask

  initial begin
    rst = 1'b1;
    tl.a_valid = 1'b0; tl.a_code = 3'd0; tl.a_param = 3'd0; tl.a_size = 2'd0; tl.a_source = 1'b0;
    tl.a_address = 32'h0; tl.a_mask = 4'h0; tl.a_data = 32'h0; tl.a_corrupt = 1'b0; tl.d_ready = 1'b0;
    test_reset();
    test_put_full();
    test_get_no_bubble();
    test_put_partial();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
